reorder_buffer: RTL and testbench

- Circular in-order reorder buffer (ROB) for the Tomasulo RISC-V core.
- Allocates a ROB id for each instruction the dispatcher issues.
- Captures results broadcast on the CDB.
- Retires at most one instruction per cycle: drives the commit/rollback side of the register file (commit flag, rd, Q, V, rollback) and a redirect PC to the fetcher.

---
 rtl/reorder_buffer_pkg.sv | 50 +++++
 rtl/reorder_buffer.sv | 142 ++++++++++++++
 tb/tb_reorder_buffer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared ROB constants, entry type and id/index helpers
package reorder_buffer_pkg;
   localparam int ROB_SIZE = 16;
   localparam int ROB_ID_W = 5;
   localparam int DATA_W   = 32;
   localparam int REG_W    = 5;
   localparam int IDX_W    = $clog2(ROB_SIZE);
   localparam int CNT_W    = IDX_W + 1;

   typedef logic [ROB_ID_W-1:0] rob_id_t;
   typedef logic [DATA_W-1:0]   data_t;
   typedef logic [REG_W-1:0]    reg_pos_t;
   typedef logic [IDX_W-1:0]    idx_t;
   typedef logic [CNT_W-1:0]    cnt_t;

   localparam rob_id_t  ZERO_ROB  = '0;
   localparam reg_pos_t ZERO_REG  = '0;
   localparam data_t    ZERO_WORD = '0;

   typedef struct packed {
      reg_pos_t rd;
      data_t    pc;
      logic     is_branch;
      logic     predicted_taken;
      logic     is_store;
      data_t    value;
      logic     jump_taken;
      data_t    target;
   } rob_entry_t;

   function automatic logic id_valid(input rob_id_t id);
      return id != ZERO_ROB && id <= rob_id_t'(ROB_SIZE);
   endfunction

   function automatic idx_t id_to_idx(input rob_id_t id);
      return IDX_W'(id - rob_id_t'(1));
   endfunction

   function automatic rob_id_t idx_to_id(input idx_t i);
      return rob_id_t'(i) + rob_id_t'(1);
   endfunction

   function automatic idx_t idx_next(input idx_t i);
      return (i == idx_t'(ROB_SIZE - 1)) ? '0 : i + idx_t'(1);
   endfunction

   function automatic data_t redirect_pc(input logic taken, input data_t target, input data_t pc);
      return taken ? target : pc + data_t'(4);
   endfunction
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB; allocates ids, captures CDB results, retires one entry per cycle.
// Optional ROB_QUERY_BYPASS_EN lets operand queries see the current CDB broadcast combinationally.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     rdy,
   input  logic     alloc_signal_from_dispatcher,
   input  reg_pos_t rd_from_dispatcher,
   input  logic     is_branch_from_dispatcher,
   input  logic     predicted_taken_from_dispatcher,
   input  data_t    pc_from_dispatcher,
   input  logic     is_store_from_dispatcher,
   output rob_id_t  rob_id_to_dispatcher,
   output logic     rob_full_to_dispatcher,
   input  rob_id_t  Q1_from_dispatcher,
   input  rob_id_t  Q2_from_dispatcher,
   output logic     ready1_to_dispatcher,
   output logic     ready2_to_dispatcher,
   output data_t    V1_to_dispatcher,
   output data_t    V2_to_dispatcher,
   input  logic     cdb_valid,
   input  rob_id_t  cdb_rob_id,
   input  data_t    cdb_value,
   input  logic     cdb_jump_taken,
   input  data_t    cdb_target_pc,
   output logic     commit_flag_to_regfile,
   output reg_pos_t rd_to_regfile,
   output rob_id_t  Q_to_regfile,
   output data_t    V_to_regfile,
   output logic     rollback_flag,
   output data_t    pc_to_fetcher,
   output logic     store_commit_flag,
   output rob_id_t  store_rob_id
);
   idx_t          head, tail, cdb_idx, q1_idx, q2_idx;
   cnt_t          count;
   logic [ROB_SIZE-1:0] busy, ready;
   rob_entry_t    ent [ROB_SIZE];
   logic          do_alloc, do_cdb, do_commit, mispredict;
   logic          hit1, hit2, byp1, byp2;

   assign rob_full_to_dispatcher = count == cnt_t'(ROB_SIZE);
   assign rob_id_to_dispatcher   = idx_to_id(tail);
   assign cdb_idx    = id_to_idx(cdb_rob_id);
   assign do_alloc   = rdy && alloc_signal_from_dispatcher && !rob_full_to_dispatcher;
   assign do_cdb     = rdy && cdb_valid && id_valid(cdb_rob_id) && busy[cdb_idx];
   assign do_commit  = rdy && count != '0 && ready[head];
   assign mispredict = ent[head].is_branch && (ent[head].jump_taken != ent[head].predicted_taken);

   assign q1_idx = id_to_idx(Q1_from_dispatcher);
   assign q2_idx = id_to_idx(Q2_from_dispatcher);
   assign hit1   = id_valid(Q1_from_dispatcher) && busy[q1_idx] && ready[q1_idx];
   assign hit2   = id_valid(Q2_from_dispatcher) && busy[q2_idx] && ready[q2_idx];
`ifdef ROB_QUERY_BYPASS_EN
   assign byp1 = cdb_valid && Q1_from_dispatcher != ZERO_ROB && cdb_rob_id == Q1_from_dispatcher;
   assign byp2 = cdb_valid && Q2_from_dispatcher != ZERO_ROB && cdb_rob_id == Q2_from_dispatcher;
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif
   assign ready1_to_dispatcher = byp1 || hit1;
   assign ready2_to_dispatcher = byp2 || hit2;
   assign V1_to_dispatcher = byp1 ? cdb_value : hit1 ? ent[q1_idx].value : ZERO_WORD;
   assign V2_to_dispatcher = byp2 ? cdb_value : hit2 ? ent[q2_idx].value : ZERO_WORD;

   // Entry payload: dispatch fields at allocation, result fields on CDB capture (validity lives in busy/ready).
   always_ff @(posedge clk) begin
      if (do_alloc) begin
         ent[tail].rd              <= rd_from_dispatcher;
         ent[tail].pc              <= pc_from_dispatcher;
         ent[tail].is_branch       <= is_branch_from_dispatcher;
         ent[tail].predicted_taken <= predicted_taken_from_dispatcher;
         ent[tail].is_store        <= is_store_from_dispatcher;
         ent[tail].value           <= ZERO_WORD;
         ent[tail].jump_taken      <= 1'b0;
         ent[tail].target          <= ZERO_WORD;
      end
      if (do_cdb) begin
         ent[cdb_idx].value      <= cdb_value;
         ent[cdb_idx].jump_taken <= cdb_jump_taken;
         ent[cdb_idx].target     <= cdb_target_pc;
      end
   end

   // Pointers, occupancy, entry status and the registered commit/rollback outputs; a mispredict flushes everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head                   <= '0;
         tail                   <= '0;
         count                  <= '0;
         busy                   <= '0;
         ready                  <= '0;
         commit_flag_to_regfile <= 1'b0;
         rd_to_regfile          <= ZERO_REG;
         Q_to_regfile           <= ZERO_ROB;
         V_to_regfile           <= ZERO_WORD;
         rollback_flag          <= 1'b0;
         pc_to_fetcher          <= ZERO_WORD;
         store_commit_flag      <= 1'b0;
         store_rob_id           <= ZERO_ROB;
      end else if (!rdy) begin
         commit_flag_to_regfile <= 1'b0;
         rollback_flag          <= 1'b0;
         store_commit_flag      <= 1'b0;
      end else begin
         commit_flag_to_regfile <= do_commit;
         rollback_flag          <= do_commit && mispredict;
         store_commit_flag      <= do_commit && ent[head].is_store;
         if (do_commit) begin
            rd_to_regfile <= ent[head].rd;
            Q_to_regfile  <= idx_to_id(head);
            V_to_regfile  <= ent[head].value;
            store_rob_id  <= idx_to_id(head);
            if (mispredict)
               pc_to_fetcher <= redirect_pc(ent[head].jump_taken, ent[head].target, ent[head].pc);
         end
         if (do_commit && mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            ready <= '0;
         end else begin
            if (do_cdb)
               ready[cdb_idx] <= 1'b1;
            if (do_alloc) begin
               busy[tail]  <= 1'b1;
               ready[tail] <= is_store_from_dispatcher;
               tail        <= idx_next(tail);
            end
            if (do_commit) begin
               busy[head]  <= 1'b0;
               ready[head] <= 1'b0;
               head        <= idx_next(head);
            end
            count <= count + cnt_t'(do_alloc) - cnt_t'(do_commit);
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed test-plan scenarios then random traffic, checked against a queue-based ROB model.
module tb_reorder_buffer;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b0;
   logic        alloc = 1'b0;
   logic [4:0]  rd = '0;
   logic        isbr = 1'b0, pred = 1'b0, isst = 1'b0;
   logic [31:0] pc = '0;
   logic [4:0]  rob_id;
   logic        rob_full;
   logic [4:0]  Q1 = '0, Q2 = '0;
   logic        ready1, ready2;
   logic [31:0] V1, V2;
   logic        cdb_v = 1'b0;
   logic [4:0]  cdb_id = '0;
   logic [31:0] cdb_val = '0, cdb_tgt = '0;
   logic        cdb_tk = 1'b0;
   logic        commit_flag, rollback, st_flag;
   logic [4:0]  rd_rf, q_rf, st_id;
   logic [31:0] v_rf, pc_f;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          id;
      logic [4:0]  rd;
      logic [31:0] pc;
      bit          br, pred, st, done, taken;
      logic [31:0] val, tgt;
   } tb_ent_t;
   tb_ent_t q[$];
   int next_id = 1;

   reorder_buffer dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .alloc_signal_from_dispatcher(alloc), .rd_from_dispatcher(rd),
      .is_branch_from_dispatcher(isbr), .predicted_taken_from_dispatcher(pred),
      .pc_from_dispatcher(pc), .is_store_from_dispatcher(isst),
      .rob_id_to_dispatcher(rob_id), .rob_full_to_dispatcher(rob_full),
      .Q1_from_dispatcher(Q1), .Q2_from_dispatcher(Q2),
      .ready1_to_dispatcher(ready1), .ready2_to_dispatcher(ready2),
      .V1_to_dispatcher(V1), .V2_to_dispatcher(V2),
      .cdb_valid(cdb_v), .cdb_rob_id(cdb_id), .cdb_value(cdb_val),
      .cdb_jump_taken(cdb_tk), .cdb_target_pc(cdb_tgt),
      .commit_flag_to_regfile(commit_flag), .rd_to_regfile(rd_rf),
      .Q_to_regfile(q_rf), .V_to_regfile(v_rf),
      .rollback_flag(rollback), .pc_to_fetcher(pc_f),
      .store_commit_flag(st_flag), .store_rob_id(st_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void qry(input int id, output logic r, output logic [31:0] v, output bit skip_v);
      r = 1'b0;
      v = '0;
      skip_v = 1'b0;
      foreach (q[i])
         if (id != 0 && q[i].id == id) begin
            r = q[i].done;
            v = q[i].done ? q[i].val : 32'h0;
            skip_v = q[i].st;
         end
`ifdef ROB_QUERY_BYPASS_EN
      if (cdb_v && id != 0 && int'(cdb_id) == id) begin
         r = 1'b1;
         v = cdb_val;
         skip_v = 1'b0;
      end
`endif
   endfunction

   task automatic idle();
      rdy = 1'b1; alloc = 1'b0; rd = '0; isbr = 1'b0; pred = 1'b0; isst = 1'b0; pc = '0;
      cdb_v = 1'b0; cdb_id = '0; cdb_val = '0; cdb_tk = 1'b0; cdb_tgt = '0; Q1 = '0; Q2 = '0;
   endtask

   task automatic put(input logic [4:0] r, input bit b, input bit p, input logic [31:0] a, input bit s);
      alloc = 1'b1; rd = r; isbr = b; pred = p; pc = a; isst = s;
   endtask

   task automatic bcast(input int id, input logic [31:0] val, input bit tk, input logic [31:0] tgt);
      cdb_v = 1'b1; cdb_id = 5'(id); cdb_val = val; cdb_tk = tk; cdb_tgt = tgt;
   endtask

   // One clock: check combinational outputs, predict the retire pulse, clock, check, then advance the model.
   task automatic cycle();
      tb_ent_t h;
      bit ec, erb, full_pre, sk;
      logic r;
      logic [31:0] v;
      #1;
      full_pre = q.size() == 16;
      chk("rob_full", rob_full, full_pre);
      chk("rob_id", rob_id, next_id);
      qry(Q1, r, v, sk);
      chk("ready1", ready1, r);
      if (!sk) chk("V1", V1, v);
      qry(Q2, r, v, sk);
      chk("ready2", ready2, r);
      if (!sk) chk("V2", V2, v);
      ec = rdy && q.size() > 0 && q[0].done;
      if (ec) h = q[0];
      erb = ec && h.br && (h.taken != h.pred);
      @(posedge clk);
      #1;
      chk("commit_flag", commit_flag, ec);
      chk("store_commit_flag", st_flag, ec && h.st);
      chk("rollback_flag", rollback, erb);
      if (ec) begin
         chk("rd_to_regfile", rd_rf, h.rd);
         chk("Q_to_regfile", q_rf, h.id);
         if (!h.st) chk("V_to_regfile", v_rf, h.val);
         if (h.st) chk("store_rob_id", st_id, h.id);
         if (erb) chk("pc_to_fetcher", pc_f, h.taken ? h.tgt : h.pc + 32'd4);
      end
      if (rdy) begin
         if (erb) begin
            q.delete();
            next_id = 1;
         end else begin
            if (cdb_v && cdb_id != 0)
               foreach (q[i])
                  if (q[i].id == int'(cdb_id)) begin
                     q[i].done = 1'b1;
                     q[i].val = cdb_val;
                     q[i].taken = cdb_tk;
                     q[i].tgt = cdb_tgt;
                  end
            if (alloc && !full_pre) begin
               q.push_back('{id: next_id, rd: rd, pc: pc, br: isbr, pred: pred, st: isst,
                             done: isst, taken: 1'b0, val: 32'h0, tgt: 32'h0});
               next_id = (next_id == 16) ? 1 : next_id + 1;
            end
            if (ec) void'(q.pop_front());
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_commit_flag", commit_flag, 1'b0);
      chk("rst_rollback", rollback, 1'b0);
      chk("rst_store_flag", st_flag, 1'b0);
      chk("rst_rd", rd_rf, 5'd0);
      chk("rst_Q", q_rf, 5'd0);
      chk("rst_V", v_rf, 32'd0);
      chk("rst_pc", pc_f, 32'd0);
      chk("rst_store_id", st_id, 5'd0);
      chk("rst_rob_id", rob_id, 5'd1);
      chk("rst_full", rob_full, 1'b0);
      q.delete();
      next_id = 1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic rand_inputs();
      int pend[$];
      idle();
      rdy = ($urandom % 8) != 0;
      if ($urandom % 2 == 1) put(5'($urandom), 1'b0, 1'($urandom), $urandom & 32'hFFFF_FFFC, ($urandom % 6) == 0);
      if (alloc && !isst) isbr = ($urandom % 4) == 0;
      foreach (q[i]) if (!q[i].done && !q[i].st) pend.push_back(i);
      if (pend.size() > 0 && $urandom % 4 != 0)
         bcast(q[pend[$urandom_range(0, pend.size() - 1)]].id, $urandom, 1'($urandom), $urandom & 32'hFFFF_FFFC);
      else if ($urandom % 3 == 0)
         bcast(0, $urandom, 1'($urandom), $urandom);
      Q1 = 5'($urandom_range(0, 16));
      Q2 = 5'($urandom_range(0, 16));
   endtask

   initial begin
      do_reset();
      // Single result round trip.
      idle(); put(5'd5, 0, 0, 32'h0, 0); cycle();
      idle(); bcast(1, 32'hDEADBEEF, 0, 0); Q1 = 5'd1; cycle();
      idle(); Q1 = 5'd1; cycle();
      idle(); cycle();
      // Out-of-order completion, in-order retirement.
      do_reset();
      for (int i = 0; i < 3; i++) begin idle(); put(5'(i + 1), 0, 0, 32'(i * 4), 0); cycle(); end
      for (int i = 3; i >= 1; i--) begin idle(); bcast(i, 32'(i * 32'h111), 0, 0); Q1 = 5'(i); Q2 = 5'd3; cycle(); end
      for (int i = 0; i < 4; i++) begin idle(); cycle(); end
      // Fill, overflow attempt, drain one, wrap.
      do_reset();
      for (int i = 0; i < 17; i++) begin idle(); put(5'(i), 0, 0, 32'(i * 4), 0); cycle(); end
      idle(); bcast(1, 32'h1234, 0, 0); cycle();
      idle(); put(5'd9, 0, 0, 32'h0, 0); cycle();
      idle(); put(5'd10, 0, 0, 32'h0, 0); cycle();
      idle(); cycle();
      // Mispredicted branch flushes younger entries.
      do_reset();
      idle(); put(5'd0, 1, 0, 32'h100, 0); cycle();
      idle(); put(5'd7, 0, 0, 32'h104, 0); cycle();
      idle(); put(5'd8, 0, 0, 32'h108, 0); bcast(1, 32'h0, 1, 32'h200); cycle();
      idle(); bcast(2, 32'h77, 0, 0); cycle();
      idle(); cycle();
      idle(); cycle();
      // Store retires without a CDB result.
      do_reset();
      idle(); put(5'd0, 0, 0, 32'h40, 1); cycle();
      idle(); cycle();
      // Async reset with entries in flight, query during broadcast.
      do_reset();
      for (int i = 0; i < 6; i++) begin idle(); put(5'(i + 1), 0, 0, 32'(i * 4), 0); cycle(); end
      idle(); bcast(2, 32'hCAFE0002, 0, 0); Q1 = 5'd2; cycle();
      idle(); bcast(1, 32'hCAFE0001, 0, 0); Q1 = 5'd2; cycle();
      idle(); cycle();
      do_reset();
      idle(); put(5'd3, 0, 0, 32'h0, 0); cycle();
      // Random traffic.
      for (int n = 0; n < 3000; n++) begin rand_inputs(); cycle(); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
